// File: rtl/ex_stage_pkg.sv
// Shared widths, one-hot op indices and bus layouts for the execute stage.
package ex_stage_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int ALU_WD   = 10;
    localparam int BRU_WD   = 8;
    localparam int DIV_WD   = 4;
    localparam int LSU_WD   = 5;
    localparam int MUL_WD   = 4;
    localparam int STALL_WD = 6;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLL  = 2;
    localparam int ALU_SLT  = 3;
    localparam int ALU_SLTU = 4;
    localparam int ALU_XOR  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_OR   = 8;
    localparam int ALU_AND  = 9;

    localparam int BRU_BEQ  = 0;
    localparam int BRU_BNE  = 1;
    localparam int BRU_BLT  = 2;
    localparam int BRU_BGE  = 3;
    localparam int BRU_BLTU = 4;
    localparam int BRU_BGEU = 5;
    localparam int BRU_JAL  = 6;
    localparam int BRU_JALR = 7;

    localparam int DIV_DIV  = 0;
    localparam int DIV_DIVU = 1;
    localparam int DIV_REM  = 2;
    localparam int DIV_REMU = 3;

    typedef logic [STALL_WD-1:0] stall_t;

    typedef struct packed {
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [XLEN-1:0]   imm;
        logic [ALU_WD-1:0] alu_op;
        logic [BRU_WD-1:0] bru_op;
        logic [LSU_WD-1:0] lsu_op;
        logic [MUL_WD-1:0] mul_op;
        logic [DIV_WD-1:0] div_op;
        logic              sel_rf_res;
        logic              rf_we;
        logic [REG_AW-1:0] rf_waddr;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
    } id2ex_t;

    typedef struct packed {
        logic [XLEN-1:0]   ex_result;
        logic [XLEN-1:0]   store_data;
        logic [LSU_WD-1:0] lsu_op;
        logic [MUL_WD-1:0] mul_op;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic              sel_rf_res;
        logic              rf_we;
        logic [REG_AW-1:0] rf_waddr;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
    } ex2mem1_t;

    // Bypass layout, MSB first: {rf_we, rf_waddr, ex_result}
    typedef struct packed {
        logic              rf_we;
        logic [REG_AW-1:0] rf_waddr;
        logic [XLEN-1:0]   ex_result;
    } bypass_t;

    localparam int ID2EX_WD   = $bits(id2ex_t);
    localparam int EX2MEM1_WD = $bits(ex2mem1_t);
    localparam int BYPASS_WD  = $bits(bypass_t);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Radix-2 restoring divider on operand magnitudes; signs are restored at the output.
module div_iter
    import ex_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signed_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            busy,
    output logic            done,
    input  logic            ack
);

    div_state_e      state_q, state_d;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q, a_q;
    logic            negq_q, negr_q, dz_q;
    logic [XLEN:0]   shifted, diff;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= DIV_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start)          state_d = DIV_BUSY;
            DIV_BUSY: if (cnt_q == 5'd31) state_d = DIV_DONE;
            DIV_DONE: if (ack)            state_d = DIV_IDLE;
            default:                      state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == DIV_BUSY);
        done = (state_q == DIV_DONE);
    end

    // Dividend bits shift out of quo_q into the partial remainder; quotient bits shift in.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            a_q    <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (state_q == DIV_IDLE && start) begin
            cnt_q  <= '0;
            quo_q  <= neg_if(signed_op & a[XLEN-1], a);
            rem_q  <= '0;
            dvs_q  <= neg_if(signed_op & b[XLEN-1], b);
            a_q    <= a;
            negq_q <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
            negr_q <= signed_op & a[XLEN-1];
            dz_q   <= (b == '0);
        end else if (state_q == DIV_BUSY) begin
            cnt_q <= cnt_q + 5'd1;
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Divide-by-zero is overridden so a negative dividend does not flip the all-ones quotient.
    assign quotient  = dz_q ? '1  : neg_if(negq_q, quo_q);
    assign remainder = dz_q ? a_q : neg_if(negr_q, rem_q);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: input register, ALU, branch resolution, iterative divider and bypass.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  stall_t          stall,
    input  id2ex_t          id2ex_bus,
    output ex2mem1_t        ex2mem1_bus,
    output bypass_t         ex2rf_bus,
    output logic            br_e,
    output logic [XLEN-1:0] br_addr,
    output logic            stallreq_ex
);

    id2ex_t          ex_q, ex_d;
    logic [XLEN-1:0] a, b, alu_res, ex_result, quo, rem;
    logic [4:0]      shamt;
    logic            taken, div_nz, div_done, div_busy;

    always_comb begin
        ex_d = ex_q;
        if ((stall[3] & ~stall[4]) | br_e) ex_d = '0;
        else if (!stall[3])                ex_d = id2ex_bus;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign a     = ex_q.src1;
    assign b     = ex_q.src2;
    assign shamt = b[4:0];

    always_comb begin
        alu_res = '0;
        if (ex_q.alu_op[ALU_ADD])  alu_res = a + b;
        if (ex_q.alu_op[ALU_SUB])  alu_res = a - b;
        if (ex_q.alu_op[ALU_SLL])  alu_res = a << shamt;
        if (ex_q.alu_op[ALU_SLT])  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        if (ex_q.alu_op[ALU_SLTU]) alu_res = {{(XLEN-1){1'b0}}, a < b};
        if (ex_q.alu_op[ALU_XOR])  alu_res = a ^ b;
        if (ex_q.alu_op[ALU_SRL])  alu_res = a >> shamt;
        if (ex_q.alu_op[ALU_SRA])  alu_res = XLEN'($signed(a) >>> shamt);
        if (ex_q.alu_op[ALU_OR])   alu_res = a | b;
        if (ex_q.alu_op[ALU_AND])  alu_res = a & b;
    end

    always_comb begin
        taken = (ex_q.bru_op[BRU_BEQ]  & (a == b))
              | (ex_q.bru_op[BRU_BNE]  & (a != b))
              | (ex_q.bru_op[BRU_BLT]  & ($signed(a) <  $signed(b)))
              | (ex_q.bru_op[BRU_BGE]  & ($signed(a) >= $signed(b)))
              | (ex_q.bru_op[BRU_BLTU] & (a <  b))
              | (ex_q.bru_op[BRU_BGEU] & (a >= b))
              | ex_q.bru_op[BRU_JAL] | ex_q.bru_op[BRU_JALR];
        br_addr = ex_q.bru_op[BRU_JALR] ? ((a + ex_q.imm) & ~XLEN'(1)) : (ex_q.pc + ex_q.imm);
    end

    assign br_e = taken & ~stall[3];

    assign div_nz = |ex_q.div_op;

    div_iter u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_nz),
        .signed_op (ex_q.div_op[DIV_DIV] | ex_q.div_op[DIV_REM]),
        .a         (a),
        .b         (b),
        .quotient  (quo),
        .remainder (rem),
        .busy      (div_busy),
        .done      (div_done),
        .ack       (~stall[3])
    );

    assign stallreq_ex = div_nz & ~div_done;

    always_comb begin
        if (div_nz)
            ex_result = (ex_q.div_op[DIV_REM] | ex_q.div_op[DIV_REMU]) ? rem : quo;
        else if (ex_q.bru_op[BRU_JAL] | ex_q.bru_op[BRU_JALR])
            ex_result = ex_q.pc + XLEN'(4);
        else
            ex_result = alu_res;
    end

    always_comb begin
        ex2mem1_bus.ex_result  = ex_result;
        ex2mem1_bus.store_data = b;
        ex2mem1_bus.lsu_op     = ex_q.lsu_op;
        ex2mem1_bus.mul_op     = ex_q.mul_op;
        ex2mem1_bus.src1       = a;
        ex2mem1_bus.src2       = b;
        ex2mem1_bus.sel_rf_res = ex_q.sel_rf_res;
        ex2mem1_bus.rf_we      = ex_q.rf_we;
        ex2mem1_bus.rf_waddr   = ex_q.rf_waddr;
        ex2mem1_bus.pc         = ex_q.pc;
        ex2mem1_bus.inst       = ex_q.inst;
    end

    // A quotient still being computed must never reach the bypass network.
    assign ex2rf_bus = '{rf_we: ex_q.rf_we & ~stallreq_ex, rf_waddr: ex_q.rf_waddr, ex_result: ex_result};

    logic unused_ok;
    assign unused_ok = ^{stall[5], stall[2:0], div_busy};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     hold;
    stall_t   stall;
    id2ex_t   id2ex_bus;
    ex2mem1_t ex2mem1_bus;
    bypass_t  ex2rf_bus;
    logic     br_e;
    logic [31:0] br_addr;
    logic     stallreq_ex;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Hazard unit stand-in: a busy divider (or an external hold) freezes EX and MEM1.
    logic s_hold;
    assign s_hold = stallreq_ex | hold;
    assign stall  = {1'b0, s_hold, s_hold, s_hold, s_hold, s_hold};

    ex_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .id2ex_bus   (id2ex_bus),
        .ex2mem1_bus (ex2mem1_bus),
        .ex2rf_bus   (ex2rf_bus),
        .br_e        (br_e),
        .br_addr     (br_addr),
        .stallreq_ex (stallreq_ex)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic id2ex_t mk(input int alu_k, input int bru_k, input int div_k,
                                  input logic [31:0] s1, input logic [31:0] s2,
                                  input logic [31:0] imm, input logic [31:0] pc);
        id2ex_t t;
        t = '0;
        t.src1 = s1;
        t.src2 = s2;
        t.imm  = imm;
        t.pc   = pc;
        if (alu_k >= 0) t.alu_op[alu_k] = 1'b1;
        if (bru_k >= 0) t.bru_op[bru_k] = 1'b1;
        if (div_k >= 0) t.div_op[div_k] = 1'b1;
        t.lsu_op     = LSU_WD'($urandom);
        t.mul_op     = MUL_WD'($urandom);
        t.sel_rf_res = 1'($urandom);
        t.rf_we      = 1'b1;
        t.rf_waddr   = REG_AW'($urandom_range(1, 31));
        t.inst       = $urandom;
        return t;
    endfunction

    function automatic logic [31:0] ref_alu(input int k, input logic [31:0] x, input logic [31:0] y);
        int sx, sy, sh;
        sx = x; sy = y; sh = int'(y % 32);
        case (k)
            0: return x + y;
            1: return x - y;
            2: return x << sh;
            3: return (sx < sy) ? 32'd1 : 32'd0;
            4: return (x < y) ? 32'd1 : 32'd0;
            5: return x ^ y;
            6: return x >> sh;
            7: return 32'(sx >>> sh);
            8: return x | y;
            9: return x & y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_taken(input int k, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        sx = x; sy = y;
        case (k)
            0: return x == y;
            1: return x != y;
            2: return sx < sy;
            3: return sx >= sy;
            4: return x < y;
            5: return x >= y;
            6, 7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_div(input int k, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        logic [31:0] q, r;
        sx = x; sy = y;
        if (y == 0) begin
            q = 32'hFFFF_FFFF; r = x;
        end else if ((k == 0 || k == 2) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0;
        end else if (k == 0 || k == 2) begin
            q = sx / sy; r = sx % sy;
        end else begin
            q = x / y; r = x % y;
        end
        return (k >= 2) ? r : q;
    endfunction

    task automatic run_op(input string tag, input id2ex_t ins, input int alu_k, input int bru_k);
        logic [31:0] exp_res, exp_tgt;
        bit tk;
        tk = (bru_k >= 0) ? ref_taken(bru_k, ins.src1, ins.src2) : 1'b0;
        if (bru_k >= 6)      exp_res = ins.pc + 32'd4;
        else if (alu_k >= 0) exp_res = ref_alu(alu_k, ins.src1, ins.src2);
        else                 exp_res = 32'd0;
        exp_tgt = (bru_k == 7) ? ((ins.src1 + ins.imm) & 32'hFFFF_FFFE) : (ins.pc + ins.imm);
        id2ex_bus = ins;
        @(posedge clk); #1;
        chk({tag, ".rf"}, ex2rf_bus, {1'b1, ins.rf_waddr, exp_res});
        chk({tag, ".br_e"}, br_e, tk);
        if (tk) chk({tag, ".br_addr"}, br_addr, exp_tgt);
        chk({tag, ".pass"}, {ex2mem1_bus.store_data, ex2mem1_bus.lsu_op, ex2mem1_bus.mul_op},
            {ins.src2, ins.lsu_op, ins.mul_op});
        if (tk) begin
            id2ex_bus = mk(0, -1, -1, $urandom, $urandom, 0, 32'h200);
            @(posedge clk); #1;
            chk({tag, ".bubble"}, ex2mem1_bus == '0, 1'b1);
            chk({tag, ".br_once"}, br_e, 1'b0);
        end
    endtask

    task automatic run_div(input string tag, input int k, input logic [31:0] x,
                           input logic [31:0] y, input bit hold_done);
        id2ex_t ins;
        logic [31:0] exp_res;
        int cyc;
        bit we_leak;
        ins = mk(-1, -1, k, x, y, 0, 32'h300);
        exp_res = ref_div(k, x, y);
        id2ex_bus = ins;
        @(posedge clk); #1;
        if (hold_done) hold = 1'b1;
        cyc = 0;
        we_leak = 1'b0;
        while (stallreq_ex && cyc < 40) begin
            if (ex2rf_bus.rf_we) we_leak = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
        chk({tag, ".stall_cycles"}, cyc, 33);
        chk({tag, ".no_fwd"}, we_leak, 1'b0);
        chk({tag, ".result"}, ex2rf_bus, {1'b1, ins.rf_waddr, exp_res});
        if (hold_done) begin
            repeat (3) @(posedge clk);
            #1;
            chk({tag, ".held_stall"}, stallreq_ex, 1'b0);
            chk({tag, ".held_result"}, ex2mem1_bus.ex_result, exp_res);
            hold = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        id2ex_t ins;
        int ak, bk, dk;
        logic [31:0] x, y;

        rst_n = 1'b0;
        hold  = 1'b0;
        id2ex_bus = mk(0, 0, 0, 32'h1, 32'h1, 32'h4, 32'h10);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ex2mem1", ex2mem1_bus == '0, 1'b1);
        chk("rst.ex2rf", ex2rf_bus, 0);
        chk("rst.br_e", br_e, 0);
        chk("rst.br_addr", br_addr, 0);
        chk("rst.stallreq", stallreq_ex, 0);
        id2ex_bus = '0;
        rst_n = 1'b1;

        run_op("addi", mk(ALU_ADD, -1, -1, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0), ALU_ADD, -1);
        run_op("beq_t", mk(-1, BRU_BEQ, -1, 32'd7, 32'd7, 32'h20, 32'h100), -1, BRU_BEQ);
        run_op("beq_nt", mk(-1, BRU_BEQ, -1, 32'd7, 32'd8, 32'h20, 32'h100), -1, BRU_BEQ);
        run_op("jalr", mk(-1, BRU_JALR, -1, 32'h2003, 32'h0, 32'h4, 32'h40), -1, BRU_JALR);

        for (int i = 0; i < 80; i++) begin
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? x : $urandom;
            if ($urandom_range(0, 4) == 0) y = y & 32'h1F;
            if ($urandom_range(0, 9) < 6) begin
                ak = $urandom_range(0, 9);
                run_op("rnd_alu", mk(ak, -1, -1, x, y, $urandom, $urandom & 32'hFFFF_FFFC), ak, -1);
            end else begin
                bk = $urandom_range(0, 7);
                run_op("rnd_bru", mk(-1, bk, -1, x, y, $urandom, $urandom & 32'hFFFF_FFFC), -1, bk);
            end
        end

        run_div("div", DIV_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("rem", DIV_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("divu0", DIV_DIVU, 32'd9, 32'd0, 1'b0);
        run_div("remu0", DIV_REMU, 32'd9, 32'd0, 1'b0);
        run_div("div_ovf", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div("div_neg0", DIV_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);
        run_div("div_hold", DIV_DIVU, 32'd1000, 32'd7, 1'b1);

        for (int i = 0; i < 6; i++) begin
            dk = $urandom_range(0, 3);
            run_div("rnd_div", dk, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(1, 20)), 1'b0);
        end

        // Reset while the divider is mid-iteration
        ins = mk(-1, -1, DIV_DIV, 32'd100, 32'd3, 0, 32'h400);
        id2ex_bus = ins;
        @(posedge clk); #1;
        repeat (11) @(posedge clk);
        #1;
        chk("mid.busy", stallreq_ex, 1'b1);
        rst_n = 1'b0;
        id2ex_bus = '0;
        @(posedge clk); #1;
        chk("mid.rst_ex2mem1", ex2mem1_bus == '0, 1'b1);
        chk("mid.rst_ex2rf", ex2rf_bus, 0);
        chk("mid.rst_stall", stallreq_ex, 0);
        chk("mid.rst_br", {br_e, br_addr}, 0);
        rst_n = 1'b1;
        run_div("post_rst", DIV_DIV, 32'd100, 32'd3, 1'b0);
        run_op("after_div", mk(ALU_SUB, -1, -1, 32'd10, 32'd3, 0, 32'h500), ALU_SUB, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the in-order RV32IM pipeline, directly downstream of the decode stage. It latches the decode-to-execute bus and resolves ALU results, branches and jumps. It also runs an iterative 32-cycle divider, stalling the front end while a divide is in flight. It drives the forwarding/bypass bus back to decode and feeds the first memory stage.

## Interface
Parameters: none. All widths come from the shared package.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stall  in  StallBus  global stall vector; bit 3 holds EX, bit 4 holds MEM1
- id2ex_bus  in  ID2EX_WD  fields: {src1, src2, imm, alu_op, bru_op, lsu_op, mul_op, div_op, sel_rf_res, rf_we, rf_waddr, pc, inst}
- ex2mem1_bus  out  EX2MEM1_WD  fields: {ex_result, store_data, lsu_op, mul_op, src1, src2, sel_rf_res, rf_we, rf_waddr, pc, inst}
- ex2rf_bus  out  BYPASS_WD (38)  fields: {rf_we, rf_waddr, ex_result}
- br_e  out  1  taken branch/jump, flush request
- br_addr  out  32  redirect target
- stallreq_ex  out  1  divider busy

## Operation
- Input register:
  - On reset, or when (stall[3] & !stall[4]) | br_e, it loads all-zero (bubble).
  - Otherwise, when !stall[3], it loads id2ex_bus.
  - Otherwise it holds.
- A zero register means no write, no branch and no divide.
- ALU (alu_op one-hot, 10 bits): add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - Shift amount is src2[4:0].
  - slt/sltu produce 0 or 1.
- Branch unit (bru_op one-hot, 8 bits): beq, bne, blt, bge, bltu, bgeu, jal, jalr.
  - Conditional branches compare src1 and src2, which carry register values.
  - Target for branches and jal is pc+imm. Target for jalr is (src1+imm) & ~1.
  - taken is 1 for jal/jalr and for a branch whose condition holds.
  - br_e = taken & !stall[3]. br_addr = target and is don't-care when br_e=0.
  - Misaligned targets are not checked.
- ex_result priority:
  1. div_op nonzero: divider result.
  2. jal/jalr: pc+4.
  3. Otherwise: ALU result.
- store_data = src2 pass-through.
- ex2rf_bus carries the latched rf_we, rf_waddr and ex_result.
  - rf_we is forced 0 while stallreq_ex=1, so an unfinished quotient is never forwarded.
- Divider (div_op one-hot, 4 bits: div, divu, rem, remu): radix-2 restoring, operating on magnitudes with sign fix-up.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
  - Special cases still take the full latency.
- Divider FSM:
  - IDLE: when div_op is nonzero, capture operands and go to BUSY with count=0.
  - BUSY: one iteration per cycle. When count=31, go to DONE.
  - DONE: hold the result until !stall[3], then go to IDLE.
  - Reset in any state returns to IDLE with count=0.
- stallreq_ex = div_op nonzero & state≠DONE.
- mul_op and lsu_op pass through. The multiplier lives in MEM1/MEM2.

## Timing
- Reset values:
  - All internal registers are 0 and the FSM is IDLE.
  - All outputs are 0: ex2mem1_bus, ex2rf_bus, br_e, br_addr, stallreq_ex.
- ALU, branch and jump results are combinational from the input register (0-cycle latency). The instruction leaves EX on the next edge with !stall[3].
- Divide timing:
  - Cycle 0: instruction enters EX, FSM is IDLE, stallreq_ex=1.
  - Cycles 1–32: BUSY, stallreq_ex=1.
  - Cycle 33: DONE, stallreq_ex=0, result valid.
  - stallreq_ex is high for exactly 33 cycles.
- A divide held in DONE by a downstream stall (stall[4]) is not restarted.
- Back-to-back divides: the second one enters IDLE on the edge the first one leaves, so it also sees 33 stall cycles.
- br_e is one cycle wide per taken instruction, because EX reloads on the same edge. On that edge EX loads a bubble.

## Structure
- Add to define.vh:
  - EX2MEM1_WD.
  - ALU_WD=10, BRU_WD=8, DIV_WD=4.
  - One-hot bit-index macros for alu_op, bru_op and div_op.
  - The BYPASS_WD field order.
- One sub-module: div_iter (clk, rst_n, start, signed_op, a, b, quotient, remainder, busy, done, ack).
- ALU and branch comparison stay inline.

## Test plan
- addi: src1=5, src2=imm=0xFFFFFFFD, alu add -> ex2rf_bus={1, rd, 2} in the same cycle.
- beq taken: src1=src2=7, pc=0x100, imm=0x20 -> br_e=1 for one cycle, br_addr=0x120, next EX content is a bubble. The same case with src2=8 -> br_e=0.
- jalr: src1=0x2003, imm=4, pc=0x40 -> br_addr=0x2006, ex_result=0x44.
- div: src1=-7, src2=2 -> stallreq_ex high for 33 cycles, ex2rf rf_we=0 during the stall, then quotient 0xFFFFFFFD. rem with the same operands -> 0xFFFFFFFF.
- divu by 0 with dividend 9 -> 0xFFFFFFFF. remu by 0 -> 9. div 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Reset asserted at BUSY count=10 -> FSM IDLE, all outputs 0 on the next cycle. A divide issued afterwards completes in 33 cycles.
